// File: rtl/dsram_axi_bridge.sv
// dsram_axi_bridge: turns one SRAM-like data request at a time into a single-beat AXI read or write.
// Latency: addr_ok is combinational in IDLE, and a read completes no sooner than 3 cycles after accept.
// Backpressure: holds ar/aw/w valid until ready, then stalls new requests (addr_ok=0) until data_ok.
//
// Ports: clock/resetn (async active-low); data_sram_* is the request/response side to the memory stage;
// ar*/r* are the AXI read channels and aw*/w*/b* the AXI write channels. There is one outstanding transaction.
// Optional: when DSRAM_BRIDGE_ERR_EN is defined, output bus_err pulses with data_ok on SLVERR/DECERR,
//           and an erroring read returns 32'h0.
module dsram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
`ifdef DSRAM_BRIDGE_ERR_EN
  output logic        bus_err,
`endif
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;
  logic [3:0]  strb_next;
  logic        aw_hs;
  logic        w_hs;
  logic        rd_err;
  logic        wr_err;

  assign data_sram_addr_ok = (state == IDLE);
  assign arid   = AXI_ID;
  assign awid   = AXI_ID;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

`ifdef DSRAM_BRIDGE_ERR_EN
  // SLVERR (2'b10) and DECERR (2'b11) both have bit 1 set.
  assign rd_err = rresp[1];
  assign wr_err = bresp[1];
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  // Byte lanes touched by the request; the address is assumed naturally aligned.
  always_comb begin
    strb_next = 4'b1111;
    case (data_sram_size)
      2'd0:    strb_next = 4'b0001 << data_sram_addr[1:0];
      2'd1:    strb_next = data_sram_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_next = 4'b1111;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      addr_q            <= 32'h0;
      size_q            <= 2'd0;
      wdata_q           <= 32'h0;
      wstrb_q           <= 4'h0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      arvalid           <= 1'b0;
      awvalid           <= 1'b0;
      wvalid            <= 1'b0;
      rready            <= 1'b0;
      bready            <= 1'b0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= 32'h0;
`ifdef DSRAM_BRIDGE_ERR_EN
      bus_err           <= 1'b0;
`endif
    end else begin
      // Completion indications are single-cycle pulses.
      data_sram_data_ok <= 1'b0;
`ifdef DSRAM_BRIDGE_ERR_EN
      bus_err           <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (data_sram_req) begin
            addr_q  <= data_sram_addr;
            size_q  <= data_sram_size;
            wdata_q <= data_sram_wdata;
            wstrb_q <= strb_next;
            if (data_sram_wr) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_AWW;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_AR;
            end
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (rvalid) begin
            rready            <= 1'b0;
            data_sram_rdata   <= rd_err ? 32'h0 : rdata;
            data_sram_data_ok <= 1'b1;
`ifdef DSRAM_BRIDGE_ERR_EN
            bus_err           <= rd_err;
`endif
            state             <= IDLE;
          end
        end
        WR_AWW: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready            <= 1'b0;
            data_sram_data_ok <= 1'b1;
`ifdef DSRAM_BRIDGE_ERR_EN
            bus_err           <= wr_err;
`endif
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // wr_err is consumed only when error reporting is built in.
  logic unused_err;
  assign unused_err = wr_err;

endmodule

// File: tb/tb_dsram_axi_bridge.sv
module tb_dsram_axi_bridge;

  logic        clock;
  logic        resetn;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
`ifdef DSRAM_BRIDGE_ERR_EN
  logic        bus_err;
`endif
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: byte-addressed memory for the low 64 bytes.
  logic [7:0]  mbytes [64];
  // Slave-side word memory, written only through the AXI W channel.
  logic [31:0] smem   [16];

  dsram_axi_bridge dut (
    .clock(clock), .resetn(resetn),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
`ifdef DSRAM_BRIDGE_ERR_EN
    .bus_err(bus_err),
`endif
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size >= 2) ? 4 : (size == 1 ? 2 : 1);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] s;
    int n;
    int base;
    n = nbytes(size);
    base = int'(addr[1:0]) & ~(n - 1);
    s = 4'h0;
    for (int i = 0; i < n; i++) s[base + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int b;
    b = int'(addr[5:0]) & ~3;
    return {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    int n;
    int base;
    n = nbytes(size);
    base = int'(addr[5:0]) & ~(n - 1);
    for (int i = 0; i < n; i++) mbytes[base + i] = wd[8*((base + i) % 4) +: 8];
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input int ard, input int rd,
                         input logic [1:0] resp, input logic [31:0] sdata, input logic [31:0] exp);
    chk("rd_addr_ok_idle", {31'b0, data_sram_addr_ok}, 32'd1);
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = size; data_sram_addr = addr;
    step();
    data_sram_req = 1'b0;
    chk("rd_data_ok_after_accept", {31'b0, data_sram_data_ok}, 32'd0);
    chk("rd_addr_ok_busy", {31'b0, data_sram_addr_ok}, 32'd0);
    chk("arid", {28'b0, arid}, 32'd1);
    chk("arsize", {29'b0, arsize}, {30'b0, size});
    for (int c = 0; c <= ard; c++) begin
      chk("araddr", araddr, addr);
      arready = (c == ard);
      step();
      arready = 1'b0;
      chk("arvalid", {31'b0, arvalid}, {31'b0, c < ard});
      chk("rready_ar", {31'b0, rready}, {31'b0, c == ard});
    end
    for (int c = 0; c <= rd; c++) begin
      rvalid = (c == rd);
      rdata  = (c == rd) ? sdata : $urandom;
      rresp  = resp;
      step();
      rvalid = 1'b0;
      if (c < rd) begin
        chk("rd_data_ok_wait", {31'b0, data_sram_data_ok}, 32'd0);
        chk("rd_addr_ok_wait", {31'b0, data_sram_addr_ok}, 32'd0);
      end else begin
        chk("rd_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
        chk("rd_rdata", data_sram_rdata, exp);
        chk("rready_done", {31'b0, rready}, 32'd0);
        chk("rd_addr_ok_done", {31'b0, data_sram_addr_ok}, 32'd1);
`ifdef DSRAM_BRIDGE_ERR_EN
        chk("rd_bus_err", {31'b0, bus_err}, {31'b0, resp[1]});
`endif
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                          input int awd, input int wdl, input int bd, input logic [1:0] resp);
    int mx;
    mx = (awd > wdl) ? awd : wdl;
    chk("wr_addr_ok_idle", {31'b0, data_sram_addr_ok}, 32'd1);
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = size;
    data_sram_addr = addr; data_sram_wdata = wd;
    step();
    data_sram_req = 1'b0;
    chk("wr_data_ok_after_accept", {31'b0, data_sram_data_ok}, 32'd0);
    chk("awid", {28'b0, awid}, 32'd1);
    chk("awaddr", awaddr, addr);
    chk("awsize", {29'b0, awsize}, {30'b0, size});
    chk("wdata", wdata, wd);
    chk("wstrb", {28'b0, wstrb}, {28'b0, exp_strb(addr, size)});
    for (int c = 0; c <= mx; c++) begin
      awready = (c == awd);
      wready  = (c == wdl);
      if (wready && wvalid && addr[31:6] == 26'h0)
        for (int l = 0; l < 4; l++)
          if (wstrb[l]) smem[addr[5:2]][8*l +: 8] = wdata[8*l +: 8];
      step();
      awready = 1'b0; wready = 1'b0;
      chk("awvalid", {31'b0, awvalid}, {31'b0, c < awd});
      chk("wvalid", {31'b0, wvalid}, {31'b0, c < wdl});
      chk("bready_aww", {31'b0, bready}, {31'b0, c == mx});
      chk("wr_addr_ok_busy", {31'b0, data_sram_addr_ok}, 32'd0);
    end
    if (addr[31:6] == 26'h0) model_write(addr, size, wd);
    for (int c = 0; c <= bd; c++) begin
      bvalid = (c == bd);
      bresp  = resp;
      step();
      bvalid = 1'b0;
      if (c < bd) begin
        chk("wr_data_ok_wait", {31'b0, data_sram_data_ok}, 32'd0);
        chk("bready_wait", {31'b0, bready}, 32'd1);
      end else begin
        chk("wr_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
        chk("bready_done", {31'b0, bready}, 32'd0);
        chk("wr_addr_ok_done", {31'b0, data_sram_addr_ok}, 32'd1);
`ifdef DSRAM_BRIDGE_ERR_EN
        chk("wr_bus_err", {31'b0, bus_err}, {31'b0, resp[1]});
`endif
      end
    end
  endtask

  task automatic idle_check();
    step();
    chk("data_ok_single", {31'b0, data_sram_data_ok}, 32'd0);
`ifdef DSRAM_BRIDGE_ERR_EN
    chk("bus_err_single", {31'b0, bus_err}, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      for (int b = 0; b < 4; b++) mbytes[4*i + b] = smem[i][8*b +: 8];
    end
    resetn = 1'b0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rdata = 0; rresp = 0; rvalid = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
    step(); step();
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'b0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'b0, wvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_bready", {31'b0, bready}, 32'd0);
    chk("rst_data_ok", {31'b0, data_sram_data_ok}, 32'd0);
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_wstrb", {28'b0, wstrb}, 32'h0);
    chk("rst_arsize", {29'b0, arsize}, 32'h0);
    chk("rst_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    resetn = 1'b1;
    step();

    // Directed: word read with arready after 2 cycles.
    do_read(32'h0000_1004, 2'd2, 2, 0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    idle_check();
    // Byte write: awready 3 cycles before wready, bvalid 1 cycle later.
    do_write(32'h0000_2003, 2'd0, 32'h5A5A_5A5A, 0, 3, 1, 2'b00);
    chk("byte_wstrb_1000", {28'b0, wstrb}, 32'h8);
    idle_check();
    // Half write with both handshakes one cycle after accept.
    do_write(32'h0000_2002, 2'd1, 32'hA5A5_A5A5, 0, 0, 0, 2'b00);
    // Back-to-back: read accepted during the write's data_ok cycle.
    do_read(32'h0000_3000, 2'd2, 0, 0, 2'b00, 32'h0BAD_F00D, 32'h0BAD_F00D);
    idle_check();
    // Write completing with wready before awready.
    do_write(32'h0000_0010, 2'd2, 32'h1234_5678, 2, 1, 0, 2'b00);
    idle_check();
    do_read(32'h0000_0010, 2'd2, 0, 1, 2'b00, smem[4], model_word(32'h10));
    idle_check();

`ifdef DSRAM_BRIDGE_ERR_EN
    do_read(32'h0000_0020, 2'd2, 0, 0, 2'b10, 32'h1111_2222, 32'h0);
    idle_check();
    do_write(32'h0000_4000, 2'd2, 32'h0, 0, 0, 0, 2'b11);
    idle_check();
`else
    // Without error reporting, error responses complete as normal.
    do_read(32'h0000_0020, 2'd2, 0, 0, 2'b10, 32'h1111_2222, 32'h1111_2222);
    idle_check();
    do_write(32'h0000_4000, 2'd2, 32'h0, 0, 0, 0, 2'b11);
    idle_check();
`endif

    // Reset while waiting for read data.
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_addr = 32'h8;
    step();
    data_sram_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("pre_rst_rready", {31'b0, rready}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_rready", {31'b0, rready}, 32'd0);
    chk("arst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("arst_data_ok", {31'b0, data_sram_data_ok}, 32'd0);
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    step();
    chk("arst_rvalid_ignored", {31'b0, data_sram_data_ok}, 32'd0);
    rvalid = 1'b0;
    resetn = 1'b1;
    step();
    chk("post_rst_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    chk("post_rst_data_ok", {31'b0, data_sram_data_ok}, 32'd0);

    // Randomized traffic against the byte-level model in the low 64 bytes.
    for (int it = 0; it < 60; it++) begin
      sz = 2'($urandom_range(0, 3));
      a  = {26'h0, 6'($urandom_range(0, 63))};
      a  = a & ~32'(nbytes(sz) - 1);
      d  = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, sz, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 2'b00);
      else
        do_read(a, sz, $urandom_range(0, 3), $urandom_range(0, 3), 2'b00, smem[a[5:2]], model_word(a));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsram_axi_bridge.md
Name: dsram_axi_bridge

Overview:
- Data-side bridge directly downstream of the memory-access stage.
- Accepts one SRAM-like request at a time (req/wr/size/addr/wdata) and converts it to single-beat AXI3/AXI4 read or write transactions.
- Returns addr_ok and data_ok, plus read data as the full 32-bit word; the memory stage does byte/halfword extraction.
- Sits between the memory-access stage and the AXI crossbar. At most one transaction is outstanding.

Parameters:
AXI_ID  4'd1  value driven on arid/awid/wid; top level ties arlen=0, arburst=INCR, lock/cache/prot=0

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
data_sram_req  in  1  request valid
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  0=byte, 1=half, 2=word
data_sram_addr  in  32  physical byte address
data_sram_wdata  in  32  write data, lanes already replicated
data_sram_addr_ok  out  1  request accepted this cycle
data_sram_data_ok  out  1  one-cycle completion pulse
data_sram_rdata  out  32  read word, valid while data_ok=1
arid  out  4  =AXI_ID
araddr  out  32  read address
arsize  out  3  {1'b0,size}
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready
awid  out  4  =AXI_ID
awaddr  out  32  write address
awsize  out  3  {1'b0,size}
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  byte strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (resetn=0, async): state=IDLE; arvalid, awvalid, wvalid, rready, bready and data_ok=0; data_sram_rdata, araddr, awaddr, wdata, wstrb, sizes=0.
- FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B.
- addr_ok = (state==IDLE), combinational. A request is accepted when req&&addr_ok. req while not IDLE is ignored.
- On accept: latch addr, size, wdata and strobes. Go to RD_AR (arvalid=1) if wr=0, or to WR_AWW (awvalid=1, wvalid=1) if wr=1.
- RD_AR: hold arvalid and araddr stable until arready. On handshake: arvalid=0, rready=1, go to RD_R.
- RD_R: on rvalid: rready=0, data_sram_rdata<=rdata, data_ok<=1 for the next cycle, state<=IDLE. rlast is ignored; single beat.
- WR_AWW: awvalid and wvalid are dropped independently on their own handshakes, including the same cycle or either order. When both are done (done flags or current handshakes): bready=1, go to WR_B.
- WR_B: on bvalid: bready=0, data_ok<=1 next cycle, state<=IDLE.
- data_ok is exactly one cycle wide. addr_ok is high in that same cycle, so a back-to-back request may be accepted while data_ok=1. Total read latency from accept ≥3 cycles.
- wstrb:
  - size0: 4'b0001<<addr[1:0]
  - size1: addr[1] ? 4'b1100 : 4'b0011
  - size2/3: 4'b1111
- araddr/awaddr carry the unmodified byte address. No alignment checks are made; the memory stage suppresses misaligned requests.
- Non-OKAY rresp/bresp completes normally unless DSRAM_BRIDGE_ERR_EN is defined.

Optional Feature:
- Macro: DSRAM_BRIDGE_ERR_EN.
- When defined:
  - Extra output bus_err (1 bit, reset 0).
  - bus_err pulses high for one cycle together with data_ok when the completing rresp/bresp is SLVERR(2'b10) or DECERR(2'b11).
  - On an erroring read, data_sram_rdata is forced to 32'h0.
- When undefined: no bus_err port; responses are ignored.

Test Plan:
- Read word 0x00001004: arready after 2 cycles, rvalid with rdata=0xDEADBEEF -> arsize=3'b010, araddr=0x00001004; data_ok single pulse with rdata=0xDEADBEEF; addr_ok low from accept until that pulse.
- Byte write addr 0x00002003, wdata 0x5A5A5A5A: awready before wready by 3 cycles, bvalid 1 cycle later -> wstrb=4'b1000, awsize=3'b000; each valid drops on its own handshake; one data_ok after bvalid.
- Half write addr 0x...2, awready and wready in same cycle as accept+1 -> wstrb=4'b1100, state reaches WR_B next cycle, bready=1.
- Back-to-back: new read request held high during data_ok of previous write -> accepted in the data_ok cycle; arvalid next cycle.
- resetn low while in RD_R -> all valids/readies 0 immediately; data_ok stays 0; after release, addr_ok=1.
- With DSRAM_BRIDGE_ERR_EN, read with rresp=2'b10 -> data_ok=1, bus_err=1, rdata=0x00000000 for one cycle.
